smi_transaction_router_x3: RTL and testbench
============================================

Name: smi_transaction_router_x3

Overview:
Downstream counterpart of the three-way SMI transaction arbiter. It takes one upstream initiator request stream and steers each request frame to one of three target ports, chosen by a match on the header flit. It merges the three target response streams back onto one upstream response port using frame-level round-robin arbitration. It is used where one initiator (or an arbiter output) fans out to three memory/peripheral targets.

Parameters:
FlitWidth, 4, bytes per flit (min 4); DataWidth = FlitWidth*8.
TargetMask, 32'h0C000000, mask applied to header flit bits [31:0].
TargetAMatch, 32'h00000000, masked header value selecting target A.
TargetBMatch, 32'h04000000, masked header value selecting target B.
TargetCMatch, 32'h08000000, masked header value selecting target C.

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
smiReqInReady/Eofc/Data  in  1/8/DataWidth  upstream request flit
smiReqInStop  out  1  upstream request backpressure
smiReqAOutReady/Eofc/Data  out  1/8/DataWidth  request to target A (likewise B, C)
smiReqAOutStop  in  1  target A backpressure (likewise B, C)
smiRespAInReady/Eofc/Data  in  1/8/DataWidth  response from target A (likewise B, C)
smiRespAInStop  out  1  backpressure to target A (likewise B, C)
smiRespOutReady/Eofc/Data  out  1/8/DataWidth  merged upstream response
smiRespOutStop  in  1  upstream response backpressure
dropCount  out  8  saturating count of discarded unmatched request frames

Behaviour:
- Clock and reset: one clock, clk. Reset srst is synchronous and active-high.
- Transfer rule: a flit transfers when Ready=1 and Stop=0 in the same cycle. Eofc=0 marks a non-final flit. Eofc!=0 marks the final flit and gives its valid byte count.
- Input buffering: every input stream (request in, response A/B/C in) enters a 2-entry skid buffer.
  - Stop = buffer full.
  - While srst=1, all Stop outputs are forced 1 and inputs are ignored.
- Reset state:
  - all buffers empty;
  - all Ready outputs 0;
  - request FSM in IDLE;
  - response arbiter in IDLE with priority pointer at A;
  - dropCount 0.
- Request FSM states: IDLE, FWD_A, FWD_B, FWD_C, DISCARD.
  - In IDLE with a head flit present, compute (head[31:0] & TargetMask) and compare in priority order A, B, C.
  - The selected output presents the head flit combinationally in the same cycle. Latency is 1 cycle from input acceptance to output Ready.
  - If that first flit transfers with Eofc=0, enter the matching FWD_x state. If it has Eofc!=0 (single-flit frame), stay in IDLE.
  - FWD_x: forward flits only to target x until the Eofc!=0 flit transfers, then return to IDLE.
  - No match: enter DISCARD (or stay in IDLE for a single-flit frame). Flits are popped at 1/cycle with no output Ready, until Eofc!=0. dropCount increments (saturating at 255) when the header is popped.
  - Non-selected outputs hold Ready=0.
  - Back-to-back frames run with zero bubble.
- Response arbiter states: IDLE, GRANT_A, GRANT_B, GRANT_C.
  - In IDLE, grant the first buffer with a head flit, starting from the priority pointer and searching cyclically. The granted head is driven out in the same cycle.
  - A grant holds until the granted stream's Eofc!=0 flit transfers.
  - After a frame completes, the pointer moves to the port after the one just served.
  - No interleaving of flits from different frames.
  - Non-granted buffers see no pop and assert Stop when full.
- Frame steering is fixed at the header. Later flits are never decoded.
- Downstream Stop held high indefinitely: the request path stalls and the upstream Stop rises once 2 flits are buffered. No flit is lost or duplicated.
- Reset mid-frame: the partial frame is abandoned, buffers are flushed and both FSMs return to IDLE the cycle after srst.

Decomposition:
- Package smi_router_pkg holds:
  - the eofc end test (eofc != 8'h00);
  - the request FSM and arbiter state enums;
  - the port index constants A=0, B=1, C=2.
- Sub-module smi_skid_buffer2: a 2-entry Ready/Stop buffer parameterised by DataWidth. It is instantiated 4 times.

Test Plan:
- Reset: hold srst 3 cycles with all inputs Ready=1 -> all Stop=1 and all out Ready=0 during reset; dropCount=0 afterwards.
- Steering: 4-flit frame with header 32'h04000010 plus 1-flit frame with header 32'h08000000, back-to-back -> 4 flits on B then 1 on C, in order, no gap, A idle.
- Unmatched header: frame with header 32'h0C000000, 3 flits -> no output Ready, all flits consumed, dropCount=1. Repeat 300 frames -> dropCount=255.
- Round-robin: A, B and C each present a 2-flit response at the same cycle, pointer at A -> output order A,A,B,B,C,C with frames unbroken.
- Backpressure: smiReqAOutStop=1 for 10 cycles mid-frame -> smiReqInStop=1 after 2 buffered flits. On release the whole frame is delivered intact.
- Reset mid-frame: srst asserted after 2 of 4 flits to C -> next frame routes correctly from IDLE, and the arbiter pointer is back at A.

Source files
------------

// File: rtl/smi_router_pkg.sv
// Shared types and helpers for the SMI three-target router: port indices, FSM encodings,
// end-of-frame test and cyclic port stepping.
package smi_router_pkg;

    localparam logic [1:0] PORT_A = 2'd0;
    localparam logic [1:0] PORT_B = 2'd1;
    localparam logic [1:0] PORT_C = 2'd2;

    typedef enum logic [2:0] {
        RQ_IDLE,
        RQ_FWD_A,
        RQ_FWD_B,
        RQ_FWD_C,
        RQ_DISCARD
    } req_state_e;

    typedef enum logic [1:0] {
        AR_IDLE,
        AR_GRANT_A,
        AR_GRANT_B,
        AR_GRANT_C
    } arb_state_e;

    function automatic logic is_eof(input logic [7:0] eofc);
        return eofc != 8'h00;
    endfunction

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == PORT_C) ? PORT_A : p + 2'd1;
    endfunction

    function automatic req_state_e fwd_state(input logic [1:0] p);
        case (p)
            PORT_B:  return RQ_FWD_B;
            PORT_C:  return RQ_FWD_C;
            default: return RQ_FWD_A;
        endcase
    endfunction

    function automatic arb_state_e grant_state(input logic [1:0] p);
        case (p)
            PORT_B:  return AR_GRANT_B;
            PORT_C:  return AR_GRANT_C;
            default: return AR_GRANT_A;
        endcase
    endfunction

endpackage

// File: rtl/smi_skid_buffer2.sv
// Two-entry Ready/Stop flit buffer; head visible the cycle after acceptance.
// Stop is raised only when both entries are occupied, and held high throughout srst.
module smi_skid_buffer2 #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 in_ready_i,
    input  logic [7:0]           in_eofc_i,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 in_stop_o,
    output logic                 out_ready_o,
    output logic [7:0]           out_eofc_o,
    output logic [DataWidth-1:0] out_data_o,
    input  logic                 pop_i
);

    logic [DataWidth+7:0] mem_q [2];
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           cnt_q;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign push  = in_ready_i & ~full & ~srst;
    assign pop   = pop_i & ~empty & ~srst;

    assign in_stop_o   = full | srst;
    assign out_ready_o = ~empty;
    assign {out_eofc_o, out_data_o} = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_eofc_i, in_data_i};
    end

endmodule

// File: rtl/smi_transaction_router_x3.sv
// Steers request frames to targets A/B/C by masked header match; merges responses by frame round-robin.
// One cycle from input acceptance to output Ready; each input stalls via its 2-entry buffer filling.
module smi_transaction_router_x3
    import smi_router_pkg::*;
#(
    parameter int          FlitWidth    = 4,
    parameter int          DataWidth    = FlitWidth * 8,
    parameter logic [31:0] TargetMask   = 32'h0C00_0000,
    parameter logic [31:0] TargetAMatch = 32'h0000_0000,
    parameter logic [31:0] TargetBMatch = 32'h0400_0000,
    parameter logic [31:0] TargetCMatch = 32'h0800_0000
) (
    input  logic                 clk,
    input  logic                 srst,

    input  logic                 smiReqInReady,
    input  logic [7:0]           smiReqInEofc,
    input  logic [DataWidth-1:0] smiReqInData,
    output logic                 smiReqInStop,

    output logic                 smiReqAOutReady,
    output logic [7:0]           smiReqAOutEofc,
    output logic [DataWidth-1:0] smiReqAOutData,
    input  logic                 smiReqAOutStop,
    output logic                 smiReqBOutReady,
    output logic [7:0]           smiReqBOutEofc,
    output logic [DataWidth-1:0] smiReqBOutData,
    input  logic                 smiReqBOutStop,
    output logic                 smiReqCOutReady,
    output logic [7:0]           smiReqCOutEofc,
    output logic [DataWidth-1:0] smiReqCOutData,
    input  logic                 smiReqCOutStop,

    input  logic                 smiRespAInReady,
    input  logic [7:0]           smiRespAInEofc,
    input  logic [DataWidth-1:0] smiRespAInData,
    output logic                 smiRespAInStop,
    input  logic                 smiRespBInReady,
    input  logic [7:0]           smiRespBInEofc,
    input  logic [DataWidth-1:0] smiRespBInData,
    output logic                 smiRespBInStop,
    input  logic                 smiRespCInReady,
    input  logic [7:0]           smiRespCInEofc,
    input  logic [DataWidth-1:0] smiRespCInData,
    output logic                 smiRespCInStop,

    output logic                 smiRespOutReady,
    output logic [7:0]           smiRespOutEofc,
    output logic [DataWidth-1:0] smiRespOutData,
    input  logic                 smiRespOutStop,

    output logic [7:0]           dropCount
);

    logic                 req_vld;
    logic [7:0]           req_eofc;
    logic [DataWidth-1:0] req_dat;
    logic                 req_pop;
    logic [31:0]          hdr_masked;
    logic                 hdr_hit;
    logic [1:0]           hdr_sel;
    logic                 route_en;
    logic [1:0]           route_idx;
    logic                 route_stop;
    logic                 discard;
    req_state_e           req_q;
    logic [7:0]           drop_q;

    smi_skid_buffer2 #(.DataWidth(DataWidth)) u_req_buf (
        .clk         (clk),
        .srst        (srst),
        .in_ready_i  (smiReqInReady),
        .in_eofc_i   (smiReqInEofc),
        .in_data_i   (smiReqInData),
        .in_stop_o   (smiReqInStop),
        .out_ready_o (req_vld),
        .out_eofc_o  (req_eofc),
        .out_data_o  (req_dat),
        .pop_i       (req_pop)
    );

    assign hdr_masked = req_dat[31:0] & TargetMask;

    always_comb begin
        hdr_hit = 1'b1;
        hdr_sel = PORT_A;
        if (hdr_masked == TargetAMatch)      hdr_sel = PORT_A;
        else if (hdr_masked == TargetBMatch) hdr_sel = PORT_B;
        else if (hdr_masked == TargetCMatch) hdr_sel = PORT_C;
        else                                 hdr_hit = 1'b0;
    end

    // Only the header is decoded; in FWD_x/DISCARD the route is pinned by state.
    always_comb begin
        route_en  = 1'b0;
        route_idx = PORT_A;
        discard   = 1'b0;
        case (req_q)
            RQ_IDLE: begin
                if (hdr_hit) begin
                    route_en  = 1'b1;
                    route_idx = hdr_sel;
                end else begin
                    discard = 1'b1;
                end
            end
            RQ_FWD_A: begin
                route_en  = 1'b1;
                route_idx = PORT_A;
            end
            RQ_FWD_B: begin
                route_en  = 1'b1;
                route_idx = PORT_B;
            end
            RQ_FWD_C: begin
                route_en  = 1'b1;
                route_idx = PORT_C;
            end
            RQ_DISCARD: discard = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (route_idx)
            PORT_B:  route_stop = smiReqBOutStop;
            PORT_C:  route_stop = smiReqCOutStop;
            default: route_stop = smiReqAOutStop;
        endcase
    end

    assign req_pop = req_vld & ((route_en & ~route_stop) | discard);

    assign smiReqAOutReady = ~srst & req_vld & route_en & (route_idx == PORT_A);
    assign smiReqBOutReady = ~srst & req_vld & route_en & (route_idx == PORT_B);
    assign smiReqCOutReady = ~srst & req_vld & route_en & (route_idx == PORT_C);
    assign smiReqAOutEofc  = req_eofc;
    assign smiReqBOutEofc  = req_eofc;
    assign smiReqCOutEofc  = req_eofc;
    assign smiReqAOutData  = req_dat;
    assign smiReqBOutData  = req_dat;
    assign smiReqCOutData  = req_dat;
    assign dropCount       = drop_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            req_q  <= RQ_IDLE;
            drop_q <= 8'h00;
        end else begin
            case (req_q)
                RQ_IDLE: begin
                    if (req_pop) begin
                        if (!hdr_hit && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                        if (!is_eof(req_eofc)) req_q <= hdr_hit ? fwd_state(hdr_sel) : RQ_DISCARD;
                    end
                end
                RQ_FWD_A, RQ_FWD_B, RQ_FWD_C, RQ_DISCARD: begin
                    if (req_pop && is_eof(req_eofc)) req_q <= RQ_IDLE;
                end
                default: req_q <= RQ_IDLE;
            endcase
        end
    end

    logic [2:0]           rsp_in_rdy;
    logic [7:0]           rsp_in_eofc [3];
    logic [DataWidth-1:0] rsp_in_dat  [3];
    logic [2:0]           rsp_in_stop;
    logic [2:0]           rsp_vld;
    logic [3:0]           rsp_vld4;
    logic [7:0]           rsp_eofc    [3];
    logic [DataWidth-1:0] rsp_dat     [3];
    logic [2:0]           rsp_pop;
    logic                 any_vld;
    logic [1:0]           pick;
    logic [1:0]           cur;
    logic                 grant_en;
    logic [1:0]           grant_idx;
    logic                 gnt_vld;
    logic                 rsp_xfer;
    arb_state_e           arb_q;
    logic [1:0]           ptr_q;

    assign rsp_in_rdy     = {smiRespCInReady, smiRespBInReady, smiRespAInReady};
    assign rsp_in_eofc[0] = smiRespAInEofc;
    assign rsp_in_eofc[1] = smiRespBInEofc;
    assign rsp_in_eofc[2] = smiRespCInEofc;
    assign rsp_in_dat[0]  = smiRespAInData;
    assign rsp_in_dat[1]  = smiRespBInData;
    assign rsp_in_dat[2]  = smiRespCInData;
    assign smiRespAInStop = rsp_in_stop[0];
    assign smiRespBInStop = rsp_in_stop[1];
    assign smiRespCInStop = rsp_in_stop[2];

    for (genvar i = 0; i < 3; i++) begin : g_rsp_buf
        smi_skid_buffer2 #(.DataWidth(DataWidth)) u_rsp_buf (
            .clk         (clk),
            .srst        (srst),
            .in_ready_i  (rsp_in_rdy[i]),
            .in_eofc_i   (rsp_in_eofc[i]),
            .in_data_i   (rsp_in_dat[i]),
            .in_stop_o   (rsp_in_stop[i]),
            .out_ready_o (rsp_vld[i]),
            .out_eofc_o  (rsp_eofc[i]),
            .out_data_o  (rsp_dat[i]),
            .pop_i       (rsp_pop[i])
        );
        assign rsp_pop[i] = rsp_xfer & (grant_idx == 2'(i));
    end

    assign rsp_vld4 = {1'b0, rsp_vld};

    // Cyclic search starting at the pointer; first populated port wins.
    always_comb begin
        any_vld = 1'b0;
        pick    = ptr_q;
        cur     = ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!any_vld && rsp_vld4[cur]) begin
                any_vld = 1'b1;
                pick    = cur;
            end
            cur = next_port(cur);
        end
    end

    always_comb begin
        grant_en  = 1'b0;
        grant_idx = PORT_A;
        case (arb_q)
            AR_IDLE: begin
                grant_en  = any_vld;
                grant_idx = pick;
            end
            AR_GRANT_A: begin
                grant_en  = 1'b1;
                grant_idx = PORT_A;
            end
            AR_GRANT_B: begin
                grant_en  = 1'b1;
                grant_idx = PORT_B;
            end
            AR_GRANT_C: begin
                grant_en  = 1'b1;
                grant_idx = PORT_C;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (grant_idx)
            PORT_B: begin
                gnt_vld        = rsp_vld[1];
                smiRespOutEofc = rsp_eofc[1];
                smiRespOutData = rsp_dat[1];
            end
            PORT_C: begin
                gnt_vld        = rsp_vld[2];
                smiRespOutEofc = rsp_eofc[2];
                smiRespOutData = rsp_dat[2];
            end
            default: begin
                gnt_vld        = rsp_vld[0];
                smiRespOutEofc = rsp_eofc[0];
                smiRespOutData = rsp_dat[0];
            end
        endcase
    end

    assign smiRespOutReady = ~srst & grant_en & gnt_vld;
    assign rsp_xfer        = smiRespOutReady & ~smiRespOutStop;

    // A grant taken in IDLE is locked even if the first flit stalls, so frames never interleave.
    always_ff @(posedge clk) begin
        if (srst) begin
            arb_q <= AR_IDLE;
            ptr_q <= PORT_A;
        end else begin
            case (arb_q)
                AR_IDLE: begin
                    if (grant_en) begin
                        if (rsp_xfer && is_eof(smiRespOutEofc)) ptr_q <= next_port(grant_idx);
                        else                                    arb_q <= grant_state(grant_idx);
                    end
                end
                default: begin
                    if (rsp_xfer && is_eof(smiRespOutEofc)) begin
                        arb_q <= AR_IDLE;
                        ptr_q <= next_port(grant_idx);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smi_transaction_router_x3.sv
// Scoreboard bench for smi_transaction_router_x3: directed frames push expectations,
// a negedge monitor pops and compares every flit that leaves the router.
module tb_smi_transaction_router_x3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst;
    logic        smiReqInReady;
    logic [7:0]  smiReqInEofc;
    logic [31:0] smiReqInData;
    logic        smiReqInStop;
    logic        smiReqAOutReady, smiReqBOutReady, smiReqCOutReady;
    logic [7:0]  smiReqAOutEofc, smiReqBOutEofc, smiReqCOutEofc;
    logic [31:0] smiReqAOutData, smiReqBOutData, smiReqCOutData;
    logic        smiReqAOutStop, smiReqBOutStop, smiReqCOutStop;
    logic        rsp_rdy  [3];
    logic [7:0]  rsp_eofc [3];
    logic [31:0] rsp_dat  [3];
    logic        rsp_stop [3];
    logic        smiRespOutReady;
    logic [7:0]  smiRespOutEofc;
    logic [31:0] smiRespOutData;
    logic        smiRespOutStop;
    logic [7:0]  dropCount;

    smi_transaction_router_x3 dut (
        .clk             (clk),
        .srst            (srst),
        .smiReqInReady   (smiReqInReady),
        .smiReqInEofc    (smiReqInEofc),
        .smiReqInData    (smiReqInData),
        .smiReqInStop    (smiReqInStop),
        .smiReqAOutReady (smiReqAOutReady),
        .smiReqAOutEofc  (smiReqAOutEofc),
        .smiReqAOutData  (smiReqAOutData),
        .smiReqAOutStop  (smiReqAOutStop),
        .smiReqBOutReady (smiReqBOutReady),
        .smiReqBOutEofc  (smiReqBOutEofc),
        .smiReqBOutData  (smiReqBOutData),
        .smiReqBOutStop  (smiReqBOutStop),
        .smiReqCOutReady (smiReqCOutReady),
        .smiReqCOutEofc  (smiReqCOutEofc),
        .smiReqCOutData  (smiReqCOutData),
        .smiReqCOutStop  (smiReqCOutStop),
        .smiRespAInReady (rsp_rdy[0]),
        .smiRespAInEofc  (rsp_eofc[0]),
        .smiRespAInData  (rsp_dat[0]),
        .smiRespAInStop  (rsp_stop[0]),
        .smiRespBInReady (rsp_rdy[1]),
        .smiRespBInEofc  (rsp_eofc[1]),
        .smiRespBInData  (rsp_dat[1]),
        .smiRespBInStop  (rsp_stop[1]),
        .smiRespCInReady (rsp_rdy[2]),
        .smiRespCInEofc  (rsp_eofc[2]),
        .smiRespCInData  (rsp_dat[2]),
        .smiRespCInStop  (rsp_stop[2]),
        .smiRespOutReady (smiRespOutReady),
        .smiRespOutEofc  (smiRespOutEofc),
        .smiRespOutData  (smiRespOutData),
        .smiRespOutStop  (smiRespOutStop),
        .dropCount       (dropCount)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int xfer_cnt  [4] = '{0, 0, 0, 0};
    int first_cyc [4] = '{-1, -1, -1, -1};
    int last_cyc  [4] = '{-1, -1, -1, -1};
    logic [39:0] exp_a [$];
    logic [39:0] exp_b [$];
    logic [39:0] exp_c [$];
    logic [39:0] exp_r [$];

    function automatic logic [39:0] fl(input logic [7:0] e, input logic [31:0] d);
        return {e, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Port 0..2 = request out A..C, 3 = merged response out.
    task automatic mon_port(input int p, input logic [39:0] act);
        logic [39:0] e;
        logic        have;
        e    = '0;
        have = 1'b0;
        case (p)
            0: if (exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
            1: if (exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
            2: if (exp_c.size() > 0) begin e = exp_c.pop_front(); have = 1'b1; end
            default: if (exp_r.size() > 0) begin e = exp_r.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL unexpected_flit port%0d got %h expected none", p, act);
        end else if (act !== e) begin
            errors++;
            $display("FAIL flit port%0d got %h expected %h", p, act, e);
        end
        xfer_cnt[p]++;
        if (first_cyc[p] < 0) first_cyc[p] = cyc;
        last_cyc[p] = cyc;
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (smiReqAOutReady && !smiReqAOutStop) mon_port(0, {smiReqAOutEofc, smiReqAOutData});
        if (smiReqBOutReady && !smiReqBOutStop) mon_port(1, {smiReqBOutEofc, smiReqBOutData});
        if (smiReqCOutReady && !smiReqCOutStop) mon_port(2, {smiReqCOutEofc, smiReqCOutData});
        if (smiRespOutReady && !smiRespOutStop) mon_port(3, {smiRespOutEofc, smiRespOutData});
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [39:0] f);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        smiReqInReady = 1'b1;
        {smiReqInEofc, smiReqInData} = f;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = !smiReqInStop;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("req_send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic req_idle();
        smiReqInReady = 1'b0;
    endtask

    task automatic send_rsp(input int p, input logic [39:0] f);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        rsp_rdy[p]  = 1'b1;
        rsp_eofc[p] = f[39:32];
        rsp_dat[p]  = f[31:0];
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = !rsp_stop[p];
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("rsp_send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic discard_frames(input int n);
        for (int i = 0; i < n; i++) begin
            send_flit(fl(8'h00, 32'hFC00_0000 | 32'(i)));
            send_flit(fl(8'h00, 32'h0400_0000));
            send_flit(fl(8'h01, 32'h0000_0000 | 32'(i)));
        end
        req_idle();
        tick(4);
    endtask

    int   n_wait;
    int   bp_base;
    int   bp_held;
    logic bp_saw;

    initial begin
        srst = 1'b1;
        smiReqInReady = 1'b1;
        smiReqInEofc  = 8'h04;
        smiReqInData  = 32'h0400_0000;
        smiReqAOutStop = 1'b0;
        smiReqBOutStop = 1'b0;
        smiReqCOutStop = 1'b0;
        smiRespOutStop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rsp_rdy[i]  = 1'b1;
            rsp_eofc[i] = 8'h04;
            rsp_dat[i]  = 32'h1234_5678;
        end

        // Reset: stops forced high, outputs quiet even with inputs offering flits.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_stops", 32'({smiReqInStop, rsp_stop[0], rsp_stop[1], rsp_stop[2]}), 32'hF);
            chk("rst_out_ready", 32'({smiReqAOutReady, smiReqBOutReady, smiReqCOutReady, smiRespOutReady}), 32'h0);
        end
        @(posedge clk);
        #1;
        srst = 1'b0;
        req_idle();
        for (int i = 0; i < 3; i++) rsp_rdy[i] = 1'b0;
        chk("rst_drop", 32'(dropCount), 32'd0);
        tick(3);

        // Steering: 4-flit frame to B (body flits look like C/unmatched headers), then 1-flit to C.
        exp_b.push_back(fl(8'h00, 32'h0400_0010));
        exp_b.push_back(fl(8'h00, 32'h0800_B001));
        exp_b.push_back(fl(8'h00, 32'h0C00_B002));
        exp_b.push_back(fl(8'h04, 32'h0000_B003));
        exp_c.push_back(fl(8'h02, 32'h0800_0000));
        send_flit(fl(8'h00, 32'h0400_0010));
        send_flit(fl(8'h00, 32'h0800_B001));
        send_flit(fl(8'h00, 32'h0C00_B002));
        send_flit(fl(8'h04, 32'h0000_B003));
        send_flit(fl(8'h02, 32'h0800_0000));
        req_idle();
        tick(4);
        chk("steer_b_count", 32'(xfer_cnt[1]), 32'd4);
        chk("steer_c_count", 32'(xfer_cnt[2]), 32'd1);
        chk("steer_a_idle", 32'(xfer_cnt[0]), 32'd0);
        chk("steer_no_gap", 32'(last_cyc[2] - first_cyc[1]), 32'd4);

        // Round-robin: all three 2-flit responses arrive together, pointer at A.
        exp_r.push_back(fl(8'h00, 32'hA000_0001));
        exp_r.push_back(fl(8'h01, 32'hA000_0002));
        exp_r.push_back(fl(8'h00, 32'hB000_0001));
        exp_r.push_back(fl(8'h02, 32'hB000_0002));
        exp_r.push_back(fl(8'h00, 32'hC000_0001));
        exp_r.push_back(fl(8'h03, 32'hC000_0002));
        fork
            begin send_rsp(0, fl(8'h00, 32'hA000_0001)); send_rsp(0, fl(8'h01, 32'hA000_0002)); rsp_rdy[0] = 1'b0; end
            begin send_rsp(1, fl(8'h00, 32'hB000_0001)); send_rsp(1, fl(8'h02, 32'hB000_0002)); rsp_rdy[1] = 1'b0; end
            begin send_rsp(2, fl(8'h00, 32'hC000_0001)); send_rsp(2, fl(8'h03, 32'hC000_0002)); rsp_rdy[2] = 1'b0; end
        join
        @(negedge clk);
        chk("rr_nongrant_stop", 32'({rsp_stop[0], rsp_stop[1], rsp_stop[2]}), 32'h3);
        tick(8);
        chk("rr_resp_count", 32'(xfer_cnt[3]), 32'd6);

        // Unmatched header: whole frame consumed silently.
        send_flit(fl(8'h00, 32'h0C00_0000));
        send_flit(fl(8'h00, 32'h0400_0000));
        send_flit(fl(8'h03, 32'h0800_0000));
        req_idle();
        tick(4);
        chk("drop_one", 32'(dropCount), 32'd1);

        // Bits outside the mask are ignored: this header selects A.
        exp_a.push_back(fl(8'h00, 32'hF3FF_FFFF));
        exp_a.push_back(fl(8'h04, 32'h0000_0AAA));
        send_flit(fl(8'h00, 32'hF3FF_FFFF));
        send_flit(fl(8'h04, 32'h0000_0AAA));
        req_idle();
        tick(4);
        chk("mask_to_a_count", 32'(xfer_cnt[0]), 32'd2);

        discard_frames(253);
        chk("drop_254", 32'(dropCount), 32'd254);
        discard_frames(1);
        chk("drop_255", 32'(dropCount), 32'd255);
        discard_frames(45);
        chk("drop_saturated", 32'(dropCount), 32'd255);

        // Backpressure on A mid-frame.
        exp_a.push_back(fl(8'h00, 32'h0000_0100));
        exp_a.push_back(fl(8'h00, 32'h0000_00A1));
        exp_a.push_back(fl(8'h00, 32'h0000_00A2));
        exp_a.push_back(fl(8'h00, 32'h0000_00A3));
        exp_a.push_back(fl(8'h00, 32'h0000_00A4));
        exp_a.push_back(fl(8'h03, 32'h0000_00A5));
        bp_base = xfer_cnt[0];
        bp_saw  = 1'b0;
        bp_held = 0;
        fork
            begin
                send_flit(fl(8'h00, 32'h0000_0100));
                send_flit(fl(8'h00, 32'h0000_00A1));
                send_flit(fl(8'h00, 32'h0000_00A2));
                send_flit(fl(8'h00, 32'h0000_00A3));
                send_flit(fl(8'h00, 32'h0000_00A4));
                send_flit(fl(8'h03, 32'h0000_00A5));
                req_idle();
            end
            begin
                n_wait = 0;
                while (xfer_cnt[0] < bp_base + 2 && n_wait < 100) begin
                    tick(1);
                    n_wait++;
                end
                if (n_wait >= 100) chk("bp_start_timeout", 32'(xfer_cnt[0]), 32'(bp_base + 2));
                smiReqAOutStop = 1'b1;
                bp_held = xfer_cnt[0];
                repeat (10) begin
                    @(negedge clk);
                    if (smiReqInStop) bp_saw = 1'b1;
                end
                tick(1);
                chk("bp_upstream_stop", 32'(bp_saw), 32'd1);
                chk("bp_no_leak", 32'(xfer_cnt[0]), 32'(bp_held));
                smiReqAOutStop = 1'b0;
            end
        join
        tick(6);
        chk("bp_frame_count", 32'(xfer_cnt[0]), 32'(bp_base + 6));

        // Move the response pointer off A, then reset mid-frame on the C path.
        exp_r.push_back(fl(8'h04, 32'hA5A5_A5A5));
        send_rsp(0, fl(8'h04, 32'hA5A5_A5A5));
        rsp_rdy[0] = 1'b0;
        tick(3);
        exp_c.push_back(fl(8'h00, 32'h0800_0000));
        exp_c.push_back(fl(8'h00, 32'hC0C0_C0C1));
        send_flit(fl(8'h00, 32'h0800_0000));
        send_flit(fl(8'h00, 32'hC0C0_C0C1));
        req_idle();
        tick(3);
        smiReqCOutStop = 1'b1;
        send_flit(fl(8'h00, 32'h0400_0000));
        req_idle();
        tick(2);
        srst = 1'b1;
        tick(2);
        srst = 1'b0;
        smiReqCOutStop = 1'b0;
        chk("midrst_drop_clear", 32'(dropCount), 32'd0);

        exp_b.push_back(fl(8'h00, 32'h0400_0020));
        exp_b.push_back(fl(8'h01, 32'h0000_BBBB));
        send_flit(fl(8'h00, 32'h0400_0020));
        send_flit(fl(8'h01, 32'h0000_BBBB));
        req_idle();

        exp_r.push_back(fl(8'h01, 32'hA000_0A0A));
        exp_r.push_back(fl(8'h01, 32'hB000_0B0B));
        fork
            begin send_rsp(0, fl(8'h01, 32'hA000_0A0A)); rsp_rdy[0] = 1'b0; end
            begin send_rsp(1, fl(8'h01, 32'hB000_0B0B)); rsp_rdy[1] = 1'b0; end
        join
        tick(5);

        n_wait = 0;
        while ((exp_a.size() + exp_b.size() + exp_c.size() + exp_r.size()) != 0 && n_wait < 100) begin
            tick(1);
            n_wait++;
        end
        chk("drain_empty", 32'(exp_a.size() + exp_b.size() + exp_c.size() + exp_r.size()), 32'd0);
        chk("total_a", 32'(xfer_cnt[0]), 32'd8);
        chk("total_b", 32'(xfer_cnt[1]), 32'd6);
        chk("total_c", 32'(xfer_cnt[2]), 32'd3);
        chk("total_resp", 32'(xfer_cnt[3]), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
